// File: rtl/mmio_uart_ctrl_pkg.sv
// Shared MMIO address map and status layout for the UART/counter responder.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package mmio_uart_ctrl_pkg;

    // Address bit that selects the MMIO region
    localparam int MMIO_REGION_BIT = 31;

    // Register offsets within the region (only addr[7:0] is decoded)
    localparam logic [7:0] MMIO_STATUS  = 8'h00;
    localparam logic [7:0] MMIO_RX      = 8'h04;
    localparam logic [7:0] MMIO_TX      = 8'h08;
    localparam logic [7:0] MMIO_CYC     = 8'h10;
    localparam logic [7:0] MMIO_INST    = 8'h14;
    localparam logic [7:0] MMIO_CNT_RST = 8'h18;

    // Status word as seen by software
    typedef struct packed {
        logic [29:0] rsvd;
        logic        rx_full;
        logic        tx_empty;
    } status_t;

    // True when the address falls in the MMIO region
    function automatic logic in_region(input logic [31:0] a);
        return a[MMIO_REGION_BIT];
    endfunction

endpackage

// File: rtl/mmio_uart_ctrl_if.sv
// Memory-stage load/store bus between the pipeline and the MMIO responder.
// Latency: rdata is valid the cycle after a load is issued.
// Backpressure: none; stall freezes the request side.
interface mmio_uart_ctrl_if;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        re;
    logic        we;
    logic        stall;
    logic [31:0] rdata;

    modport master (output addr, output wdata, output re, output we, output stall, input rdata);
    modport slave  (input addr, input wdata, input re, input we, input stall, output rdata);
endinterface

// File: rtl/mmio_uart_ctrl_byte_buf1.sv
// One-entry byte buffer with push/pop and a full flag.
// Latency: pushed byte visible the cycle after the push.
// Backpressure: push ignored while full (registered flag), pop ignored while empty.
module byte_buf1 (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       push,
    input  logic [7:0] push_dat,
    input  logic       pop,
    output logic [7:0] dat,
    output logic       full
);

    logic       full_q, full_d;
    logic [7:0] dat_q, dat_d;

    // Next-state: push only into an empty slot, pop only a full one
    always_comb begin
        full_d = full_q;
        dat_d  = dat_q;
        if (pop && full_q) begin
            full_d = 1'b0;
        end
        if (push && !full_q) begin
            full_d = 1'b1;
            dat_d  = push_dat;
        end
    end

    // Buffer state, cleared asynchronously so a pending byte is lost on reset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            full_q <= 1'b0;
            dat_q  <= 8'h00;
        end else begin
            full_q <= full_d;
            dat_q  <= dat_d;
        end
    end

    assign dat  = dat_q;
    assign full = full_q;

endmodule

// File: rtl/mmio_uart_ctrl.sv
// MMIO responder for addr[31]=1: UART TX/RX byte buffers plus cycle/instret counters.
// Latency: load data registered, valid one cycle after re.
// Backpressure: TX writes dropped while full; rx_ready low while RX byte unread; stall freezes requests.
module mmio_uart_ctrl
    import mmio_uart_ctrl_pkg::*;
#(
    parameter int CNT_W = 32
) (
    input  logic                   clk,
    input  logic                   rst_n,
    mmio_uart_ctrl_if.slave        bus,
    input  logic                   inst_retire,
    output logic [7:0]             tx_data,
    output logic                   tx_valid,
    input  logic                   tx_ready,
    input  logic [7:0]             rx_data,
    input  logic                   rx_valid,
    output logic                   rx_ready
);

    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    logic       sel, ld, st;
    logic [7:0] off;
    logic       tx_full, rx_full;
    logic [7:0] rx_buf;
    logic       tx_push, tx_pop, rx_pop, cnt_clr;

    logic [31:0]      rdata_q, rdata_d;
    logic [CNT_W-1:0] cycle_cnt_q, cycle_cnt_d;
    logic [CNT_W-1:0] inst_cnt_q, inst_cnt_d;
    status_t          status;

    // Upper address and store-data bits are deliberately not decoded
    logic unused_bits;
    assign unused_bits = ^{bus.addr[30:8], bus.wdata[31:8]};

    assign sel     = in_region(bus.addr) && !bus.stall;
    assign ld      = bus.re && sel;
    assign st      = bus.we && sel;
    assign off     = bus.addr[7:0];
    assign tx_push = st && (off == MMIO_TX);
    assign tx_pop  = tx_full && tx_ready;
    assign rx_pop  = ld && (off == MMIO_RX);
    assign cnt_clr = st && (off == MMIO_CNT_RST);

    assign tx_valid = tx_full;
    assign rx_ready = !rx_full;

    byte_buf1 u_tx_buf (
        .clk      (clk),
        .rst_n    (rst_n),
        .push     (tx_push),
        .push_dat (bus.wdata[7:0]),
        .pop      (tx_pop),
        .dat      (tx_data),
        .full     (tx_full)
    );

    // RX push is gated inside the buffer by its own full flag, matching rx_ready
    byte_buf1 u_rx_buf (
        .clk      (clk),
        .rst_n    (rst_n),
        .push     (rx_valid),
        .push_dat (rx_data),
        .pop      (rx_pop),
        .dat      (rx_buf),
        .full     (rx_full)
    );

    // Read mux: counters return their pre-edge value; unmapped offsets read 0
    always_comb begin
        status = '{rsvd: '0, rx_full: rx_full, tx_empty: !tx_full};
        rdata_d = rdata_q;
        if (ld) begin
            case (off)
                MMIO_STATUS: rdata_d = status;
                MMIO_RX:     rdata_d = {24'h0, rx_buf};
                MMIO_CYC:    rdata_d = 32'(cycle_cnt_q);
                MMIO_INST:   rdata_d = 32'(inst_cnt_q);
                default:     rdata_d = 32'h0;
            endcase
        end
    end

    // Counters: clear wins over increment, both wrap naturally
    always_comb begin
        cycle_cnt_d = cycle_cnt_q + CNT_ONE;
        inst_cnt_d  = inst_retire ? inst_cnt_q + CNT_ONE : inst_cnt_q;
        if (cnt_clr) begin
            cycle_cnt_d = '0;
            inst_cnt_d  = '0;
        end
    end

    // Load data and counter registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdata_q     <= 32'h0;
            cycle_cnt_q <= '0;
            inst_cnt_q  <= '0;
        end else begin
            rdata_q     <= rdata_d;
            cycle_cnt_q <= cycle_cnt_d;
            inst_cnt_q  <= inst_cnt_d;
        end
    end

    assign bus.rdata = rdata_q;

endmodule

// File: tb/tb_mmio_uart_ctrl.sv
// Directed self-checking bench for mmio_uart_ctrl.
// Latency: loads checked one cycle after issue.
// Backpressure: TX/RX buffer full/empty behaviour exercised directly.
module tb_mmio_uart_ctrl;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       inst_retire = 1'b0;
    logic [7:0] tx_data, tx_data2;
    logic       tx_valid, tx_valid2;
    logic       tx_ready = 1'b0;
    logic [7:0] rx_data = 8'h00;
    logic       rx_valid = 1'b0;
    logic       rx_ready, rx_ready2;

    int checks = 0;
    int failures = 0;

    mmio_uart_ctrl_if bus ();
    mmio_uart_ctrl_if bus2 ();

    mmio_uart_ctrl #(.CNT_W(32)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .bus         (bus),
        .inst_retire (inst_retire),
        .tx_data     (tx_data),
        .tx_valid    (tx_valid),
        .tx_ready    (tx_ready),
        .rx_data     (rx_data),
        .rx_valid    (rx_valid),
        .rx_ready    (rx_ready)
    );

    // Narrow-counter instance used to observe wrap-around in a few cycles
    mmio_uart_ctrl #(.CNT_W(4)) dut_w4 (
        .clk         (clk),
        .rst_n       (rst_n),
        .bus         (bus2),
        .inst_retire (1'b0),
        .tx_data     (tx_data2),
        .tx_valid    (tx_valid2),
        .tx_ready    (1'b0),
        .rx_data     (8'h00),
        .rx_valid    (1'b0),
        .rx_ready    (rx_ready2)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_load(input logic [31:0] a);
        bus.addr = a;
        bus.re   = 1'b1;
        tick();
        bus.re   = 1'b0;
    endtask

    task automatic do_store(input logic [31:0] a, input logic [31:0] d);
        bus.addr  = a;
        bus.wdata = d;
        bus.we    = 1'b1;
        tick();
        bus.we    = 1'b0;
    endtask

    task automatic rx_fill(input logic [7:0] b);
        rx_data  = b;
        rx_valid = 1'b1;
        tick();
        rx_valid = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) tick();
        checks++; if (bus.rdata !== 32'h0) begin failures++; $display("FAIL reset_rdata got=%h exp=%h", bus.rdata, 32'h0); end
        checks++; if (tx_valid !== 1'b0) begin failures++; $display("FAIL reset_tx_valid got=%b exp=0", tx_valid); end
        checks++; if (tx_data !== 8'h00) begin failures++; $display("FAIL reset_tx_data got=%h exp=00", tx_data); end
        checks++; if (rx_ready !== 1'b1) begin failures++; $display("FAIL reset_rx_ready got=%b exp=1", rx_ready); end
        rst_n = 1'b1;
        repeat (5) tick();
        do_load(32'h8000_0010);
        checks++; if (bus.rdata !== 32'd4 && bus.rdata !== 32'd5) begin failures++; $display("FAIL reset_cycle_cnt got=%0d exp=4or5", bus.rdata); end
    endtask

    task automatic test_tx();
        tx_ready = 1'b0;
        do_store(32'h8000_0008, 32'h0000_0123);
        checks++; if (tx_valid !== 1'b1) begin failures++; $display("FAIL tx_valid_set got=%b exp=1", tx_valid); end
        checks++; if (tx_data !== 8'h23) begin failures++; $display("FAIL tx_data got=%h exp=23", tx_data); end
        do_store(32'h8000_0008, 32'h0000_0055);
        checks++; if (tx_data !== 8'h23) begin failures++; $display("FAIL tx_drop_when_full got=%h exp=23", tx_data); end
        do_load(32'h8000_0000);
        checks++; if (bus.rdata !== 32'h0) begin failures++; $display("FAIL tx_status_full got=%h exp=0", bus.rdata); end
        tx_ready = 1'b1;
        tick();
        tx_ready = 1'b0;
        checks++; if (tx_valid !== 1'b0) begin failures++; $display("FAIL tx_handshake_clear got=%b exp=0", tx_valid); end
        do_load(32'h8000_0000);
        checks++; if (bus.rdata !== 32'h1) begin failures++; $display("FAIL tx_status_empty got=%h exp=1", bus.rdata); end
    endtask

    task automatic test_rx();
        rx_data  = 8'hA5;
        rx_valid = 1'b1;
        tick();
        checks++; if (rx_ready !== 1'b0) begin failures++; $display("FAIL rx_ready_full got=%b exp=0", rx_ready); end
        rx_data = 8'h5A;
        tick();
        rx_valid = 1'b0;
        do_load(32'h8000_0000);
        checks++; if (bus.rdata !== 32'h3) begin failures++; $display("FAIL rx_status_full got=%h exp=3", bus.rdata); end
        do_load(32'h8000_0004);
        checks++; if (bus.rdata !== 32'h0000_00A5) begin failures++; $display("FAIL rx_data got=%h exp=a5", bus.rdata); end
        checks++; if (rx_ready !== 1'b1) begin failures++; $display("FAIL rx_pop_ready got=%b exp=1", rx_ready); end
        do_load(32'h8000_0000);
        checks++; if (bus.rdata !== 32'h1) begin failures++; $display("FAIL rx_status_after_pop got=%h exp=1", bus.rdata); end
    endtask

    task automatic test_counters();
        inst_retire = 1'b1;
        do_store(32'h8000_0018, 32'h0);
        inst_retire = 1'b0;
        do_load(32'h8000_0014);
        checks++; if (bus.rdata !== 32'h0) begin failures++; $display("FAIL cnt_clear_inst got=%0d exp=0", bus.rdata); end
        do_load(32'h8000_0010);
        checks++; if (bus.rdata !== 32'd1) begin failures++; $display("FAIL cnt_clear_cycle got=%0d exp=1", bus.rdata); end
        for (int i = 0; i < 10; i++) begin
            inst_retire = (i % 2 == 0);
            tick();
        end
        inst_retire = 1'b0;
        do_load(32'h8000_0014);
        checks++; if (bus.rdata !== 32'd5) begin failures++; $display("FAIL cnt_inst got=%0d exp=5", bus.rdata); end
        bus.stall = 1'b1;
        do_store(32'h8000_0018, 32'h0);
        bus.stall = 1'b0;
        do_load(32'h8000_0014);
        checks++; if (bus.rdata !== 32'd5) begin failures++; $display("FAIL cnt_stalled_clear got=%0d exp=5", bus.rdata); end
    endtask

    task automatic test_wrap();
        bus2.addr  = 32'h8000_0018;
        bus2.wdata = 32'h0;
        bus2.we    = 1'b1;
        tick();
        bus2.we   = 1'b0;
        bus2.addr = 32'h8000_0010;
        bus2.re   = 1'b1;
        for (int i = 0; i < 20; i++) begin
            tick();
            checks++;
            if (bus2.rdata !== 32'(i % 16)) begin
                failures++;
                $display("FAIL wrap_cycle_%0d got=%h exp=%h", i, bus2.rdata, 32'(i % 16));
            end
        end
        bus2.re = 1'b0;
    endtask

    task automatic test_stall();
        logic [31:0] prev;
        rx_fill(8'h3C);
        prev = bus.rdata;
        bus.stall = 1'b1;
        do_load(32'h8000_0004);
        checks++; if (bus.rdata !== prev) begin failures++; $display("FAIL stall_rdata_hold got=%h exp=%h", bus.rdata, prev); end
        checks++; if (rx_ready !== 1'b0) begin failures++; $display("FAIL stall_no_pop got=%b exp=0", rx_ready); end
        do_store(32'h8000_0008, 32'h77);
        checks++; if (tx_valid !== 1'b0) begin failures++; $display("FAIL stall_no_store got=%b exp=0", tx_valid); end
        bus.stall = 1'b0;
        do_load(32'h8000_0004);
        checks++; if (bus.rdata !== 32'h3C) begin failures++; $display("FAIL stall_release_pop got=%h exp=3c", bus.rdata); end
        checks++; if (rx_ready !== 1'b1) begin failures++; $display("FAIL stall_release_ready got=%b exp=1", rx_ready); end
    endtask

    task automatic test_unmapped();
        do_load(32'h8000_0020);
        checks++; if (bus.rdata !== 32'h0) begin failures++; $display("FAIL unmapped_load got=%h exp=0", bus.rdata); end
        do_store(32'h0000_0008, 32'h99);
        checks++; if (tx_valid !== 1'b0) begin failures++; $display("FAIL low_store got=%b exp=0", tx_valid); end
        rx_fill(8'h44);
        do_load(32'h0000_0004);
        checks++; if (rx_ready !== 1'b0) begin failures++; $display("FAIL low_load_no_pop got=%b exp=0", rx_ready); end
        checks++; if (bus.rdata !== 32'h0) begin failures++; $display("FAIL low_load_hold got=%h exp=0", bus.rdata); end
        do_load(32'h8000_0004);
        checks++; if (bus.rdata !== 32'h44) begin failures++; $display("FAIL low_then_pop got=%h exp=44", bus.rdata); end
    endtask

    task automatic test_back_to_back();
        do_store(32'h8000_0008, 32'h11);
        checks++; if (tx_valid !== 1'b1) begin failures++; $display("FAIL b2b_first got=%b exp=1", tx_valid); end
        tx_ready  = 1'b1;
        bus.addr  = 32'h8000_0008;
        bus.wdata = 32'h22;
        bus.we    = 1'b1;
        tick();
        bus.we   = 1'b0;
        tx_ready = 1'b0;
        checks++; if (tx_valid !== 1'b0) begin failures++; $display("FAIL b2b_write_dropped got=%b exp=0", tx_valid); end
        do_store(32'h8000_0008, 32'h33);
        checks++; if (tx_data !== 8'h33) begin failures++; $display("FAIL b2b_next_write got=%h exp=33", tx_data); end
    endtask

    task automatic test_reset_mid();
        rx_fill(8'h12);
        checks++; if (tx_valid !== 1'b1) begin failures++; $display("FAIL rstmid_pre_tx got=%b exp=1", tx_valid); end
        #2;
        rst_n = 1'b0;
        #1;
        checks++; if (tx_valid !== 1'b0) begin failures++; $display("FAIL rstmid_tx_async got=%b exp=0", tx_valid); end
        checks++; if (rx_ready !== 1'b1) begin failures++; $display("FAIL rstmid_rx_async got=%b exp=1", rx_ready); end
        tick();
        rst_n = 1'b1;
        tick();
        do_load(32'h8000_0000);
        checks++; if (bus.rdata !== 32'h1) begin failures++; $display("FAIL rstmid_status got=%h exp=1", bus.rdata); end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.addr   = 32'h0;
        bus.wdata  = 32'h0;
        bus.re     = 1'b0;
        bus.we     = 1'b0;
        bus.stall  = 1'b0;
        bus2.addr  = 32'h0;
        bus2.wdata = 32'h0;
        bus2.re    = 1'b0;
        bus2.we    = 1'b0;
        bus2.stall = 1'b0;
        test_reset();
        test_tx();
        test_rx();
        test_counters();
        test_wrap();
        test_stall();
        test_unmapped();
        test_back_to_back();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
